// File: rtl/ones_word_gen.sv
// rtl/ones_word_gen.sv - serially builds a word holding a requested number of 1s, one bit per clock.
// Define ONES_GEN_MSB_ALIGN_EN to shift 1s in from the MSB end (left-justified word).
module ones_word_gen #(
   parameter int word_size    = 4,
   parameter int counter_size = 3,
   parameter int state_size   = 2
) (
   input  logic                    clk,
   input  logic                    reset_b,
   input  logic [counter_size-1:0] count_in,
   input  logic                    count_ready,
   input  logic                    data_ack,
   output logic [word_size-1:0]    data,
   output logic                    data_ready,
   output logic                    start,
   output logic                    done,
   output logic                    error
);

   typedef enum logic [state_size-1:0] {
      ST_IDLE   = 2'b00,
      ST_BUILD  = 2'b01,
      ST_DONE   = 2'b10,
      ST_UNUSED = 2'b11
   } state_t;

   localparam logic [counter_size-1:0] WORD_MAX = counter_size'(word_size);

   state_t                  r_state;
   logic [counter_size-1:0] r_remaining;
   logic [word_size-1:0]    r_data;
   logic                    r_data_ready;
   logic                    r_start;
   logic                    r_done;
   logic                    r_error;

   state_t                  w_state_nx;
   logic [counter_size-1:0] w_remaining_nx;
   logic [word_size-1:0]    w_data_nx;
   logic                    w_data_ready_nx;
   logic                    w_start_nx;
   logic                    w_done_nx;
   logic                    w_error_nx;
   logic                    w_over;
   logic [word_size-1:0]    w_shifted;

   assign w_over = (count_in > WORD_MAX);

`ifdef ONES_GEN_MSB_ALIGN_EN
   assign w_shifted = {1'b1, r_data[word_size-1:1]};
`else
   assign w_shifted = {r_data[word_size-2:0], 1'b1};
`endif

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_state      <= ST_IDLE;
         r_remaining  <= '0;
         r_data       <= '0;
         r_data_ready <= 1'b0;
         r_start      <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_remaining  <= w_remaining_nx;
         r_data       <= w_data_nx;
         r_data_ready <= w_data_ready_nx;
         r_start      <= w_start_nx;
         r_done       <= w_done_nx;
         r_error      <= w_error_nx;
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_remaining_nx  = r_remaining;
      w_data_nx       = r_data;
      w_data_ready_nx = r_data_ready;
      w_start_nx      = 1'b0;
      w_done_nx       = r_done;
      w_error_nx      = r_error;
      case (r_state)
         ST_IDLE: begin
            if (count_ready) begin
               // Oversized requests saturate to a full word and raise error.
               w_remaining_nx = w_over ? WORD_MAX : count_in;
               w_error_nx     = w_over;
               w_data_nx      = '0;
               w_start_nx     = 1'b1;
               w_state_nx     = ST_BUILD;
            end
         end
         ST_BUILD: begin
            if (r_remaining != '0) begin
               w_data_nx      = w_shifted;
               w_remaining_nx = r_remaining - counter_size'(1);
            end else begin
               w_done_nx       = 1'b1;
               w_data_ready_nx = 1'b1;
               w_state_nx      = ST_DONE;
            end
         end
         ST_DONE: begin
            // data is left holding the last word after the ack.
            if (data_ack) begin
               w_done_nx       = 1'b0;
               w_data_ready_nx = 1'b0;
               w_error_nx      = 1'b0;
               w_state_nx      = ST_IDLE;
            end
         end
         default: begin
            w_state_nx      = ST_IDLE;
            w_remaining_nx  = '0;
            w_data_nx       = '0;
            w_data_ready_nx = 1'b0;
            w_done_nx       = 1'b0;
            w_error_nx      = 1'b0;
         end
      endcase
   end

   assign data       = r_data;
   assign data_ready = r_data_ready;
   assign start      = r_start;
   assign done       = r_done;
   assign error      = r_error;

endmodule

// File: tb/tb_ones_word_gen.sv
// tb/tb_ones_word_gen.sv - scoreboard bench for ones_word_gen with a popcount loopback check.
module tb_ones_word_gen;

   localparam int WS = 4;
   localparam int CS = 3;

   logic          clk = 1'b0;
   logic          reset_b;
   logic [CS-1:0] count_in;
   logic          count_ready;
   logic          data_ack;
   logic [WS-1:0] data;
   logic          data_ready;
   logic          start;
   logic          done;
   logic          error;

   ones_word_gen #(
      .word_size(WS),
      .counter_size(CS),
      .state_size(2)
   ) dut (
      .clk(clk),
      .reset_b(reset_b),
      .count_in(count_in),
      .count_ready(count_ready),
      .data_ack(data_ack),
      .data(data),
      .data_ready(data_ready),
      .start(start),
      .done(done),
      .error(error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [WS-1:0] word;
      logic          err;
      int            ones;
      int            e0;
      int            lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int c);
      return (c > WS) ? WS : c;
   endfunction

   // Reference word: k ones packed against the LSB (or MSB when aligned left).
   function automatic logic [WS-1:0] model_word(input int c);
      int          k;
      logic [31:0] v;
      k = sat(c);
      v = (32'd1 << k) - 32'd1;
`ifdef ONES_GEN_MSB_ALIGN_EN
      v = v << (WS - k);
`endif
      return v[WS-1:0];
   endfunction

   task automatic push_exp(input int c);
      exp_t e;
      e.word = model_word(c);
      e.err  = (c > WS);
      e.ones = sat(c);
      e.e0   = cyc + 1;
      e.lat  = sat(c) + 1;
      sb.push_back(e);
   endtask

   task automatic run_req(input int c, input int hold, input bit toggle);
      logic [WS+2:0] snap;
      logic [WS-1:0] snap_data;
      @(negedge clk);
      count_in    = CS'(c);
      count_ready = 1'b1;
      push_exp(c);
      @(negedge clk);
      count_ready = 1'b0;
      check("start_pulse", 32'(start), 32'd1);
      for (int i = 0; i < 20 && !data_ready; i++) @(negedge clk);
      if (!data_ready) begin
         check("done_timeout", 32'd0, 32'd1);
         reset_b = 1'b0;
         sb.delete();
         @(negedge clk);
         reset_b = 1'b1;
         return;
      end
      snap      = {data, error, done, data_ready};
      snap_data = data;
      for (int i = 0; i < hold; i++) begin
         count_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
         count_in    = CS'($urandom_range(0, 7));
         @(negedge clk);
         check("done_hold", 32'({data, error, done, data_ready, start}), 32'({snap, 1'b0}));
      end
      count_ready = 1'b0;
      data_ack    = 1'b1;
      @(negedge clk);
      data_ack = 1'b0;
      check("ack_clear", 32'({done, data_ready, error, start}), 32'd0);
      check("ack_data_keep", 32'(data), 32'(snap_data));
      @(negedge clk);
   endtask

   initial begin
      reset_b     = 1'b0;
      count_in    = '0;
      count_ready = 1'b0;
      data_ack    = 1'b0;

      fork
         begin : monitor
            bit   seen;
            exp_t e;
            seen = 1'b0;
            forever begin
               @(negedge clk);
               if (!reset_b) begin
                  seen = 1'b0;
               end else if (data_ready && !seen) begin
                  seen = 1'b1;
                  if (sb.size() == 0) begin
                     check("unexpected_done", 32'd1, 32'd0);
                  end else begin
                     e = sb.pop_front();
                     check("data", 32'(data), 32'(e.word));
                     check("error", 32'(error), 32'(e.err));
                     check("done_flag", 32'(done), 32'd1);
                     check("loopback_ones", 32'($countones(data)), 32'(e.ones));
                     check("latency", 32'(cyc - e.e0), 32'(e.lat));
                  end
               end else if (!data_ready) begin
                  seen = 1'b0;
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({data, data_ready, start, done, error}), 32'd0);
      reset_b = 1'b1;
      @(negedge clk);

      run_req(3, 10, 1'b1);
      run_req(0, 2, 1'b1);
      run_req(4, 1, 1'b0);
      run_req(6, 3, 1'b1);
      run_req(7, 0, 1'b0);

      @(negedge clk);
      count_in    = CS'(3);
      count_ready = 1'b1;
      push_exp(3);
      @(negedge clk);
      count_ready = 1'b0;
      @(negedge clk);
      check("mid_build_word", 32'(data), 32'(model_word(1)));
      #2 reset_b = 1'b0;
      #1 check("async_reset", 32'({data, data_ready, start, done, error}), 32'd0);
      sb.delete();
      @(negedge clk);
      reset_b = 1'b1;
      @(negedge clk);
      run_req(2, 1, 1'b0);

      for (int c = 0; c <= WS; c++) run_req(c, 0, 1'b0);

      for (int i = 0; i < 20; i++)
         run_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
